aes_mixcolumns_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_mixcol_word.sv | 22 ++
 rtl/aes_mixcolumns_seq.sv | 91 +++++++++
 tb/tb_aes_mixcolumns_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, state type and the MixColumns FSM encoding.
package aes_pkg;

  localparam logic [7:0] AES_GF_POLY = 8'h1B;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mixcol_state_t;

  // Multiply by 2 in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mixcol_word.sv
// Combinational MixColumns on one 32-bit column (row 0 in the MSB byte).
module aes_mixcol_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a  [4];
  logic [7:0] a2 [4];

  // b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign a[gi]  = col_in[31-8*gi -: 8];
      assign a2[gi] = xtime(a[gi]);
      assign col_out[31-8*gi -: 8] = a2[gi] ^ a2[(gi+1)%4] ^ a[(gi+1)%4]
                                   ^ a[(gi+2)%4] ^ a[(gi+3)%4];
    end
  endgenerate

endmodule

// File: rtl/aes_mixcolumns_seq.sv
// Column-serial AES MixColumns: one column per clock, valid/ready in and out,
// with a per-block bypass for the final round.
module aes_mixcolumns_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  mixcol_state_t state_reg, state_next;
  logic [1:0]    col_cnt_reg;
  aes_state_t    work_reg;
  aes_state_t    state_out_reg, state_out_next;
  logic          bypass_reg;
  logic          out_valid_reg;

  logic [31:0]   work_cols [4];
  logic [31:0]   col_in;
  logic [31:0]   col_out;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign work_cols[gi] = work_reg[127-32*gi -: 32];
    end
  endgenerate

  assign col_in = work_cols[col_cnt_reg];

  aes_mixcol_word u_word (
    .col_in  (col_in),
    .col_out (col_out)
  );

  // A bypassed block spends a single BUSY cycle copying the work register.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (bypass_reg || col_cnt_reg == 2'd3) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    state_out_next = state_out_reg;
    if (state_reg == BUSY) begin
      if (bypass_reg) begin
        state_out_next = work_reg;
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (col_cnt_reg == c[1:0]) state_out_next[127-32*c -: 32] = col_out;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      col_cnt_reg   <= 2'd0;
      work_reg      <= '0;
      state_out_reg <= '0;
      bypass_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      state_out_reg <= state_out_next;
      out_valid_reg <= (state_next == DONE);
      if (state_reg == IDLE && in_valid) begin
        work_reg    <= state_in;
        bypass_reg  <= bypass;
        col_cnt_reg <= 2'd0;
      end else if (state_reg == BUSY && !bypass_reg) begin
        col_cnt_reg <= col_cnt_reg + 2'd1;
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign state_out = state_out_reg;

endmodule

// File: tb/tb_aes_mixcolumns_seq.sv
// Scoreboard bench for aes_mixcolumns_seq: directed vectors plus a model-checked random burst.
module tb_aes_mixcolumns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int checks = 0;
  int errors = 0;
  int transfers = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_mixcolumns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  function automatic logic [7:0] m2(input logic [7:0] x);
    return x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] s, input logic byp);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    if (byp) return s;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = m2(a0) ^ (m2(a1) ^ a1) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ m2(a1) ^ (m2(a2) ^ a2) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ m2(a2) ^ (m2(a3) ^ a3);
      r[103-32*c -: 8] = (m2(a0) ^ a0) ^ a1 ^ a2 ^ m2(a3);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every completed output handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      transfers++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", state_out);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        check("xfer_data", state_out, e);
        $display("xfer %0d cyc %0d data %h", transfers, cyc, state_out);
      end
    end
  end

  // Issue one block; returns the cycle stamp of the accepting edge.
  task automatic send(input logic [127:0] d, input logic byp, input logic [127:0] exp,
                      output int t_acc);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    in_valid = 1'b1; state_in = d; bypass = byp;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    t_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic latency(input string name, input int want);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check(name, 128'(n), 128'(want));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t_prev;
    logic prev_byp;
    logic [127:0] snap, d;
    logic stable;
    logic [7:0] byp_pat;

    rst_n = 1'b0; in_valid = 1'b0; state_in = '0; bypass = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_state_out", state_out, 128'd0);
    @(posedge clk); #1;

    // FIPS-197 round 1
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, t);
    latency("fips_latency", 4);
    wait_idle();

    // Classic per-column vectors
    send(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, t);
    latency("col_latency", 4);
    wait_idle();

    // Bypass
    send(128'h00112233445566778899aabbccddeeff, 1'b1, 128'h00112233445566778899aabbccddeeff, t);
    latency("bypass_latency", 1);
    wait_idle();

    // Backpressure in DONE
    out_ready = 1'b0;
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, t);
    latency("bp_latency", 4);
    snap = state_out;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        in_valid = 1'b1; state_in = 128'hffeeddccbbaa99887766554433221100; bypass = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (state_out !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("bp_hold", 128'(stable), 128'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 128'(out_valid), 128'd0);
    check("bp_release_ready", 128'(in_ready), 128'd1);
    repeat (8) @(posedge clk);
    #1 check("bp_transfer_count", 128'(transfers), 128'd4);

    // Reset after column 1 has been computed
    send(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 128'h0, t);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_state_out", state_out, 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, t);
    latency("rst_new_latency", 4);
    wait_idle();

    // Back-to-back random blocks with mixed bypass
    byp_pat = 8'b1011_0010;
    prev_byp = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 8; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, byp_pat[k], ref_block(d, byp_pat[k]), t);
      if (k > 0) check("b2b_spacing", 128'(t - t_prev), prev_byp ? 128'd3 : 128'd6);
      t_prev = t;
      prev_byp = byp_pat[k];
    end

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    #1 check("queue_drained", 128'(exp_q.size()), 128'd0);
    check("total_transfers", 128'(transfers), 128'd13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
